// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures a flattened n x p float matrix and streams it one word per handshake.
// Define MATRIX_SERIALIZER_EXC_FLAG_EN to add z_exc / exc_seen inf-NaN flags.
module matrix_result_serializer #(
  parameter int n = 2,
  parameter int p = 2,
  parameter int IDXW = (n * p > 1) ? $clog2(n * p) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:32*n*p-1]   matrix_in,
  input  logic                in_stb,
  output logic                in_ack,
  output logic [31:0]         z,
  output logic                z_stb,
  input  logic                z_ack,
  output logic [IDXW-1:0]     z_idx,
  output logic                z_last,
  output logic                busy
`ifdef MATRIX_SERIALIZER_EXC_FLAG_EN
  ,
  output logic                z_exc,
  output logic                exc_seen
`endif
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(n * p - 1);
  state_t state;
  logic [0:32*n*p-1] mat;
  logic armed;
  logic capture;
  logic xfer;
  logic [IDXW-1:0] nidx;
  assign capture = state == IDLE && in_stb && armed;
  assign xfer = state == SEND && z_stb && z_ack;
  assign nidx = z_idx + 1'b1;
  // armed drops on capture and only re-arms once in_stb is seen low
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mat <= '0;
      armed <= 1'b1;
      in_ack <= 1'b0;
      z <= '0;
      z_stb <= 1'b0;
      z_idx <= '0;
      z_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      in_ack <= capture;
      armed <= !in_stb || (armed && !capture);
      if (capture) begin
        state <= SEND;
        mat <= matrix_in;
        z <= matrix_in[0 +: 32];
        z_idx <= '0;
        z_stb <= 1'b1;
        z_last <= LAST == '0;
        busy <= 1'b1;
      end else if (xfer && z_last) begin
        state <= IDLE;
        z_stb <= 1'b0;
        z_last <= 1'b0;
        z_idx <= '0;
        busy <= 1'b0;
      end else if (xfer) begin
        z <= mat[32 * int'(nidx) +: 32];
        z_idx <= nidx;
        z_last <= nidx == LAST;
      end
    end
`ifdef MATRIX_SERIALIZER_EXC_FLAG_EN
  assign z_exc = (z[30:23] == 8'hFF) && z_stb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) exc_seen <= 1'b0;
    else if (capture) exc_seen <= 1'b0;
    else if (xfer && z[30:23] == 8'hFF) exc_seen <= 1'b1;
`endif
endmodule
